// File: rtl/btb_predictor.sv
// ============================================================================
// Module      : btb_predictor
// Description : Direct-mapped branch target buffer with 2-bit saturating
//               direction counters, combinational lookup, and a post-reset
//               valid-clearing sweep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btb_predictor #(
    parameter int unsigned INDEX_BITS = 10,
    parameter int unsigned TAG_BITS   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] lookup_pc,
    output logic [15:0] pred_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    input  logic        upd_valid,
    input  logic [15:0] upd_pc,
    input  logic        upd_taken,
    input  logic [15:0] upd_target,
    input  logic        inv_valid,
    input  logic [15:0] inv_pc,
    output logic        busy
);

    localparam int unsigned           c_depth    = 1 << INDEX_BITS;
    localparam logic [INDEX_BITS-1:0] c_last_idx = '1;

    typedef enum logic [0:0] {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [INDEX_BITS-1:0]   sweep_idx_q, sweep_idx_d;

    logic                    valid_q  [c_depth];
    logic [TAG_BITS-1:0]     tag_q    [c_depth];
    logic [15:0]             target_q [c_depth];
    logic [1:0]              ctr_q    [c_depth];

    function automatic logic [INDEX_BITS-1:0] pc_index(input logic [15:0] pc);
        return pc[INDEX_BITS:1];
    endfunction

    function automatic logic [TAG_BITS-1:0] pc_tag(input logic [15:0] pc);
        return pc[INDEX_BITS+TAG_BITS:INDEX_BITS+1];
    endfunction

    // ------------------------------------------------------------------
    // Sweep / run control
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SWEEP;
            sweep_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        busy        = 1'b0;
        case (state_q)
            SWEEP: begin
                busy        = 1'b1;
                sweep_idx_d = sweep_idx_q + 1'b1;
                if (sweep_idx_q == c_last_idx) begin
                    state_d     = RUN;
                    sweep_idx_d = '0;
                end
            end
            RUN: begin
                busy = 1'b0;
            end
            default: begin
                state_d     = SWEEP;
                sweep_idx_d = '0;
                busy        = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Combinational lookup
    // ------------------------------------------------------------------
    logic                  w_run;
    logic [INDEX_BITS-1:0] w_lk_idx;
    logic [TAG_BITS-1:0]   w_lk_tag;
    logic [15:0]           w_lk_seq;

    assign w_run    = (state_q == RUN);
    assign w_lk_idx = pc_index(lookup_pc);
    assign w_lk_tag = pc_tag(lookup_pc);
    assign w_lk_seq = lookup_pc + 16'd2;

    assign pred_hit   = w_run && valid_q[w_lk_idx] && (tag_q[w_lk_idx] == w_lk_tag);
    assign pred_taken = pred_hit && ctr_q[w_lk_idx][1];
    assign pred_pc    = pred_taken ? target_q[w_lk_idx] : w_lk_seq;

    // ------------------------------------------------------------------
    // Update / invalidate decode
    // ------------------------------------------------------------------
    logic                  w_upd_en;
    logic                  w_inv_en;
    logic [INDEX_BITS-1:0] w_upd_idx;
    logic [TAG_BITS-1:0]   w_upd_tag;
    logic [INDEX_BITS-1:0] w_inv_idx;
    logic                  w_upd_hit;
    logic                  w_upd_blocked;
    logic                  w_upd_wr;
    logic                  w_upd_alloc;
    logic [1:0]            w_ctr_cur;
    logic [1:0]            w_ctr_new;
    logic                  w_unused;

    // A strobe that is not a clean 1 (including X) leaves the table alone.
    assign w_upd_en  = w_run && (upd_valid == 1'b1);
    assign w_inv_en  = w_run && (inv_valid == 1'b1);
    assign w_upd_idx = pc_index(upd_pc);
    assign w_upd_tag = pc_tag(upd_pc);
    assign w_inv_idx = pc_index(inv_pc);
    assign w_upd_hit = valid_q[w_upd_idx] && (tag_q[w_upd_idx] == w_upd_tag);
    assign w_ctr_cur = ctr_q[w_upd_idx];

    // An invalidate to the same index overrides the update completely.
    assign w_upd_blocked = w_inv_en && (w_inv_idx == w_upd_idx);
    assign w_upd_wr      = w_upd_en && !w_upd_blocked && (w_upd_hit || upd_taken);
    assign w_upd_alloc   = w_upd_wr && !w_upd_hit;

    assign w_unused = ^{upd_pc, inv_pc};

    always_comb begin
        w_ctr_new = w_ctr_cur;
        if (!w_upd_hit) begin
            w_ctr_new = 2'd2;
        end else if (upd_taken) begin
            if (w_ctr_cur != 2'd3) begin
                w_ctr_new = w_ctr_cur + 2'd1;
            end
        end else begin
            if (w_ctr_cur != 2'd0) begin
                w_ctr_new = w_ctr_cur - 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Table storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state_q == SWEEP) begin
            valid_q[sweep_idx_q] <= 1'b0;
        end else begin
            if (w_upd_alloc) begin
                valid_q[w_upd_idx] <= 1'b1;
            end
            if (w_inv_en) begin
                valid_q[w_inv_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_upd_wr) begin
            tag_q[w_upd_idx] <= w_upd_tag;
            ctr_q[w_upd_idx] <= w_ctr_new;
            if (upd_taken) begin
                target_q[w_upd_idx] <= upd_target;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_btb_predictor.sv
// ============================================================================
// Module      : tb_btb_predictor
// Description : Directed, scoreboard-checked bench for btb_predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btb_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] lookup_pc;
    logic [15:0] pred_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic        inv_valid;
    logic [15:0] inv_pc;
    logic        busy;

    always #5 clk = ~clk;

    btb_predictor #(
        .INDEX_BITS (10),
        .TAG_BITS   (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lookup_pc  (lookup_pc),
        .pred_pc    (pred_pc),
        .pred_hit   (pred_hit),
        .pred_taken (pred_taken),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target),
        .inv_valid  (inv_valid),
        .inv_pc     (inv_pc),
        .busy       (busy)
    );

    typedef struct {
        string       name;
        logic        hit;
        logic        taken;
        logic [15:0] npc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Drive a lookup, queue its expectation, then compare once outputs settle.
    task automatic look(input logic [15:0] pc, input logic hit, input logic taken,
                        input logic [15:0] npc, input string name);
        exp_t e;
        lookup_pc = pc;
        sb.push_back('{name, hit, taken, npc});
        #1;
        e = sb.pop_front();
        chk({e.name, "_hit"},   {31'd0, pred_hit},   {31'd0, e.hit});
        chk({e.name, "_taken"}, {31'd0, pred_taken}, {31'd0, e.taken});
        chk({e.name, "_pc"},    {16'd0, pred_pc},    {16'd0, e.npc});
    endtask

    task automatic step();
        @(negedge clk);
        upd_valid = 1'b0;
        inv_valid = 1'b0;
    endtask

    task automatic upd(input logic [15:0] pc, input logic tk, input logic [15:0] tgt);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tgt;
    endtask

    // Counts busy cycles; pokes an update at cycle 100 that must be ignored.
    task automatic count_busy(output int n);
        n         = 0;
        upd_pc    = 16'h0004;
        upd_taken = 1'b1;
        upd_target = 16'hBEEF;
        while (busy === 1'b1 && n < 3000) begin
            n++;
            upd_valid = (n == 100);
            @(negedge clk);
        end
        upd_valid = 1'b0;
    endtask

    initial begin
        int n;
        int m;
        rst        = 1'b1;
        lookup_pc  = 16'h0000;
        upd_valid  = 1'b0;
        upd_pc     = 16'h0000;
        upd_taken  = 1'b0;
        upd_target = 16'h0000;
        inv_valid  = 1'b0;
        inv_pc     = 16'h0000;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd1);
        look(16'h0010, 1'b0, 1'b0, 16'h0012, "reset_lookup");
        rst = 1'b0;

        count_busy(n);
        chk("sweep_len", n, 32'd1024);
        chk("run_busy", {31'd0, busy}, 32'd0);
        look(16'h0004, 1'b0, 1'b0, 16'h0006, "sweep_upd_ignored");
        look(16'h1234, 1'b0, 1'b0, 16'h1236, "post_sweep_miss");

        upd(16'h0010, 1'b1, 16'h0200);
        step();
        look(16'h0010, 1'b1, 1'b1, 16'h0200, "alloc_hit");
        look(16'h0810, 1'b0, 1'b0, 16'h0812, "tag_mismatch");

        upd(16'h0010, 1'b0, 16'h7777); step();
        look(16'h0010, 1'b1, 1'b0, 16'h0012, "ctr1");
        upd(16'h0010, 1'b0, 16'h7777); step();
        look(16'h0010, 1'b1, 1'b0, 16'h0012, "ctr0");
        upd(16'h0010, 1'b0, 16'h7777); step();
        look(16'h0010, 1'b1, 1'b0, 16'h0012, "ctr0_sat");
        upd(16'h0010, 1'b1, 16'h0300); step();
        look(16'h0010, 1'b1, 1'b0, 16'h0012, "ctr_up1");
        upd(16'h0010, 1'b1, 16'h0300); step();
        look(16'h0010, 1'b1, 1'b1, 16'h0300, "ctr_up2");
        upd(16'h0010, 1'b1, 16'h0300); step();
        look(16'h0010, 1'b1, 1'b1, 16'h0300, "ctr_up3");
        upd(16'h0010, 1'b1, 16'h0300); step();
        upd(16'h0010, 1'b0, 16'h7777); step();
        look(16'h0010, 1'b1, 1'b1, 16'h0300, "ctr3_sat_tgt_kept");
        upd(16'h0010, 1'b0, 16'h7777); step();
        look(16'h0010, 1'b1, 1'b0, 16'h0012, "ctr_down1");

        upd(16'h0020, 1'b1, 16'h0400); step();
        look(16'h0020, 1'b1, 1'b1, 16'h0400, "alloc_0020");
        upd(16'h0020, 1'b1, 16'h0500);
        inv_valid = 1'b1;
        inv_pc    = 16'h0020;
        look(16'h0020, 1'b1, 1'b1, 16'h0400, "same_cycle_old");
        step();
        look(16'h0020, 1'b0, 1'b0, 16'h0022, "inv_wins");

        upd(16'h0030, 1'b1, 16'h0600); step();
        upd(16'h0040, 1'b1, 16'h0700);
        inv_valid = 1'b1;
        inv_pc    = 16'h0030;
        step();
        look(16'h0030, 1'b0, 1'b0, 16'h0032, "inv_diff_idx");
        look(16'h0040, 1'b1, 1'b1, 16'h0700, "upd_diff_idx");

        inv_valid = 1'b1;
        inv_pc    = 16'h0810;
        step();
        look(16'h0010, 1'b0, 1'b0, 16'h0012, "inv_any_tag");

        upd(16'h0050, 1'b0, 16'h0800); step();
        look(16'h0050, 1'b0, 1'b0, 16'h0052, "miss_nt_no_alloc");
        look(16'hFFFE, 1'b0, 1'b0, 16'h0000, "pc_wrap");

        upd(16'h0060, 1'b1, 16'h0900); step();
        look(16'h0060, 1'b1, 1'b1, 16'h0900, "alloc_0060");
        rst = 1'b1;
        step();
        rst = 1'b0;
        m = 0;
        repeat (500) begin
            if (busy === 1'b1) m++;
            @(negedge clk);
        end
        chk("pre_restart_busy", m, 32'd500);
        rst = 1'b1;
        look(16'h0060, 1'b0, 1'b0, 16'h0062, "mid_sweep_lookup");
        step();
        rst = 1'b0;
        count_busy(n);
        chk("restart_sweep_len", n, 32'd1024);
        look(16'h0060, 1'b0, 1'b0, 16'h0062, "restart_cleared");
        look(16'h0040, 1'b0, 1'b0, 16'h0042, "restart_cleared2");
        look(16'h0004, 1'b0, 1'b0, 16'h0006, "restart_upd_ignored");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/btb_predictor.md
BTB_PREDICTOR -- requirements
Module: btb_predictor

Interface
REQ-001 The block SHALL take parameter INDEX_BITS, default 10: table depth is 2^INDEX_BITS entries.
REQ-002 The block SHALL take parameter TAG_BITS, default 5: tag width per entry; INDEX_BITS+TAG_BITS <= 15 is required.
REQ-003 The block SHALL have port clk  in  1  single clock, all state updates on posedge.
REQ-004 The block SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 The block SHALL have port lookup_pc  in  16  fetch PC to predict for.
REQ-006 The block SHALL have port pred_pc  out  16  predicted next PC.
REQ-007 The block SHALL have port pred_hit  out  1  valid entry with matching tag at lookup_pc.
REQ-008 The block SHALL have port pred_taken  out  1  hit and counter >= 2.
REQ-009 The block SHALL have port upd_valid  in  1  resolved-branch update strobe, sampled on posedge.
REQ-010 The block SHALL have port upd_pc  in  16  PC of the resolved branch.
REQ-011 The block SHALL have port upd_taken  in  1  resolved branch direction.
REQ-012 The block SHALL have port upd_target  in  16  resolved branch target.
REQ-013 The block SHALL have port inv_valid  in  1  invalidate strobe, for stores into code.
REQ-014 The block SHALL have port inv_pc  in  16  PC whose index is invalidated.
REQ-015 The block SHALL have port busy  out  1  reset sweep in progress.

Function
REQ-016 Index SHALL be pc[INDEX_BITS:1]; tag SHALL be pc[INDEX_BITS+TAG_BITS:INDEX_BITS+1]; pc[0] SHALL be ignored.
REQ-017 Each entry SHALL hold valid, tag[TAG_BITS], target[16], and a 2-bit saturating counter ctr.
REQ-018 Lookup SHALL be combinational, zero latency: pred_pc = target when pred_taken, else lookup_pc+2, mod 2^16 (0xFFFE+2 -> 0x0000).
REQ-019 Lookup in the same cycle as an update or invalidate to the same index SHALL return pre-edge contents.
REQ-020 Update hit, i.e. valid and tag match: taken increments ctr, saturating at 3, and writes target=upd_target; not-taken decrements ctr, saturating at 0, and leaves target unchanged.
REQ-021 Update miss with upd_taken=1 SHALL allocate: valid=1, tag=upd tag, target=upd_target, ctr=2.
REQ-022 Update miss with upd_taken=0 SHALL leave the entry unchanged.
REQ-023 Invalidate SHALL clear valid at index(inv_pc) irrespective of tag.
REQ-024 Simultaneous update and invalidate to the same index: invalidate SHALL win. Different indices: both SHALL take effect.
REQ-025 States SHALL be SWEEP and RUN. SWEEP clears valid of entry sweep_idx each cycle, sweep_idx counting 0 .. 2^INDEX_BITS-1. After the last index is cleared, the block SHALL move to RUN on the next edge.
REQ-026 In SWEEP: busy=1, pred_hit=0, pred_taken=0, pred_pc=lookup_pc+2, and upd_valid/inv_valid SHALL be ignored.
REQ-027 In RUN: busy=0.
REQ-028 An X on upd_valid or inv_valid SHALL be treated as 0.

Reset
REQ-029 When rst=1 at a posedge, the block SHALL enter SWEEP with sweep_idx=0 and busy=1 from the following cycle. rst asserted mid-sweep SHALL restart the sweep at index 0.
REQ-030 The sweep SHALL take exactly 2^INDEX_BITS cycles after rst deasserts (1024 at default), then busy=0. Reset values while sweeping: busy=1, pred_hit=0, pred_taken=0.

Verification
REQ-031 Reset for 1 cycle, count cycles with busy=1 -> exactly 1024; all lookups miss afterwards; pred_pc=lookup_pc+2.
REQ-032 Update pc=0x0010, taken, target=0x0200; then lookup 0x0010 -> pred_hit=1, pred_taken=1, pred_pc=0x0200; lookup 0x0810 (same index, different tag) -> hit=0, pred_pc=0x0812.
REQ-033 From ctr=2, apply 2 not-taken updates at 0x0010 -> pred_taken=0, pred_pc=0x0012; then 3 taken updates -> ctr=3; one more taken update holds ctr at 3.
REQ-034 Same cycle: upd_valid for 0x0020 taken and inv_valid for 0x0020 -> entry invalid after the edge; the lookup during that cycle shows old contents.
REQ-035 Lookup 0xFFFE miss -> pred_pc=0x0000; rst asserted at sweep index 500 -> sweep restarts, busy stays high 1024 further cycles.
